mem_client_arbiter: RTL and testbench
=====================================

# mem_client_arbiter

Round-robin arbiter that multiplexes `num_ports` independent memory clients onto the single `mem_cmd` / `mem_write` / `mem_read` FIFO triple consumed by the MIG adapter in the `clk_mem` domain. Each client issues 65-bit commands with attached write data or expected read data. The arbiter grants one client at a time and holds the grant until that transaction's data phase completes. At most one transaction is outstanding, so read data always returns to the client that requested it.

## Interface
- `num_ports`, 4: number of clients (2..8).
- `mem_width`, 32: data word width.
- `clk`  in  1: memory-domain clock (`uiclk`).
- `aresetn`  in  1: asynchronous active-low reset.
- `cl_cmd_valid`  in  num_ports: per-client command valid.
- `cl_cmd_ready`  out  num_ports: per-client command accept.
- `cl_cmd_data`  in  num_ports×65: per-client command. Fields:
  - bit 64 = `read_not_write`
  - [63:32] = word address
  - [31:0] = length in words
- `cl_write_valid` / `cl_write_ready`  in / out  num_ports: per-client write handshake.
- `cl_write_data`  in  num_ports×mem_width: per-client write words.
- `cl_read_valid`  out  num_ports: per-client read valid.
- `cl_read_ready`  in  num_ports: per-client read ready.
- `cl_read_data`  out  num_ports×mem_width: per-client read words.
- `mem_cmd_valid`  out  1, `mem_cmd_ready`  in  1, `mem_cmd_data`  out  65: shared command channel to the adapter.
- `mem_write_valid`  out  1, `mem_write_ready`  in  1, `mem_write_data`  out  mem_width: shared write channel.
- `mem_read_valid`  in  1, `mem_read_ready`  out  1, `mem_read_data`  in  mem_width: shared read channel.

## Operation
- All channels use valid/ready handshakes. A transfer occurs on a rising `clk` edge where both valid and ready are high.
- FSM states: IDLE, CMD, WRITE, READ.
- **IDLE**
  - Search starts at index `last_grant+1` and wraps modulo num_ports. The first client with `cl_cmd_valid` high wins.
  - On a win: latch `grant` and `cmd_reg` from that client; pulse `cl_cmd_ready[grant]` for exactly that cycle; go to CMD.
  - No valid client: stay in IDLE.
- **CMD**
  - `mem_cmd_valid`=1 and `mem_cmd_data`=`cmd_reg` until `mem_cmd_ready`.
  - On acceptance:
    - load `remaining` = length;
    - length 0 → IDLE;
    - otherwise → READ if bit 64 is set, else WRITE.
- **WRITE**
  - Combinational pass-through: `mem_write_valid`=`cl_write_valid[grant]`, `mem_write_data`=`cl_write_data[grant]`, `cl_write_ready[grant]`=`mem_write_ready`.
  - Decrement `remaining` on each transfer. Transfer with `remaining`==1 → IDLE.
- **READ**
  - Combinational pass-through: `cl_read_valid[grant]`=`mem_read_valid`, `cl_read_data[grant]`=`mem_read_data`, `mem_read_ready`=`cl_read_ready[grant]`.
  - Decrement `remaining` on each transfer. Last word → IDLE.
- Leaving READ/WRITE for IDLE sets `last_grant`=`grant`.
- Non-granted clients: all ready/valid outputs are 0. `cl_read_data` is driven for every client (value only qualified by valid).
- Outside READ: `mem_read_ready`=0, so stray read data is back-pressured and never dropped. Outside WRITE: `mem_write_valid`=0.
- `remaining` is 32 bits and never underflows. Length 0xFFFFFFFF is legal.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = num_ports-1 (port 0 wins first), `remaining` = 0, `cmd_reg` = 0;
  - all valid/ready outputs = 0, data outputs = 0.
- Latency:
  - client command accepted in the IDLE cycle it is seen;
  - `mem_cmd_valid` rises on the next cycle;
  - the first data beat can pass on the cycle after `mem_cmd` acceptance.
- Data phase: zero-latency pass-through, full throughput (one word per cycle).
- Minimum gap between back-to-back transactions: 2 cycles (IDLE + CMD), plus adapter stall.
- Simultaneous requests: only the winner sees ready. Losers keep their valid asserted (clients must hold command stable).
- Reset mid-transaction: immediate return to reset values. An in-flight burst is abandoned; the adapter is reset by the same `aresetn`.

## Structure
- Package `mem_arb_pkg`:
  - `mem_cmd_t` packed struct {`read_not_write`, `addr[31:0]`, `len[31:0]`}, 65 bits;
  - `arb_state_t` enum.
- Sub-module `rr_select`: combinational round-robin picker with inputs (`req`, `last_grant`) and outputs (`found`, `index`). Everything else is in the top module.

## Test plan
- Single write: port 2 cmd {0, 0x100, 4} with data 0xA0..0xA3 → `mem_cmd_data`=0x0_00000100_00000004; exactly 4 `mem_write` beats in order; FSM back to IDLE.
- Single read: port 1 cmd {1, 0x40, 3}; adapter returns 0x11, 0x22, 0x33 → only `cl_read_valid[1]` pulses, carrying those 3 words.
- Contention: all 4 ports request writes of length 1 simultaneously from reset → grant order 0,1,2,3, then 0 again on re-request.
- Back-pressure: `mem_write_ready` toggled 1-0-1-0 during an 8-word write → 8 beats, no duplicates or drops; `cl_write_ready` mirrors `mem_write_ready`.
- Length 0: port 3 cmd {1, 0x0, 0} → one `mem_cmd` beat; `mem_read_ready` stays 0; next grant goes to the following port.
- Reset mid-read: deassert `aresetn` after 2 of 5 read words → all outputs 0 immediately; after release, port 0 wins first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory client arbiter.
package mem_arb_pkg;

    // Client command word: {read_not_write, addr, len}, 65 bits.
    typedef struct packed {
        logic        read_not_write;
        logic [31:0] addr;
        logic [31:0] len;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWrite,
        StRead
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_select #(
    parameter int unsigned num_ports = 4,
    localparam int unsigned IdxW = $clog2(num_ports)
) (
    input  logic [num_ports-1:0] req,
    input  logic [IdxW-1:0]      last_grant,
    output logic                 found,
    output logic [IdxW-1:0]      index
);

    int unsigned cand;

    // Scan offsets 1..num_ports so last_grant itself is checked last.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned off = 1; off <= num_ports; off++) begin
            cand = 32'(last_grant) + off;
            if (cand >= num_ports) begin
                cand = cand - num_ports;
            end
            if (!found && req[IdxW'(cand)]) begin
                found = 1'b1;
                index = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_client_arbiter.sv
// Round-robin arbiter multiplexing memory clients onto one cmd/write/read channel set.
module mem_client_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned num_ports = 4,
    parameter int unsigned mem_width = 32
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [num_ports-1:0]                 cl_cmd_valid,
    output logic [num_ports-1:0]                 cl_cmd_ready,
    input  logic [num_ports-1:0][64:0]           cl_cmd_data,
    input  logic [num_ports-1:0]                 cl_write_valid,
    output logic [num_ports-1:0]                 cl_write_ready,
    input  logic [num_ports-1:0][mem_width-1:0]  cl_write_data,
    output logic [num_ports-1:0]                 cl_read_valid,
    input  logic [num_ports-1:0]                 cl_read_ready,
    output logic [num_ports-1:0][mem_width-1:0]  cl_read_data,
    output logic                                 mem_cmd_valid,
    input  logic                                 mem_cmd_ready,
    output logic [64:0]                          mem_cmd_data,
    output logic                                 mem_write_valid,
    input  logic                                 mem_write_ready,
    output logic [mem_width-1:0]                 mem_write_data,
    input  logic                                 mem_read_valid,
    output logic                                 mem_read_ready,
    input  logic [mem_width-1:0]                 mem_read_data
);

    localparam int unsigned IdxW = $clog2(num_ports);

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic [31:0]     remaining_q, remaining_d;
    logic            sel_found;
    logic [IdxW-1:0] sel_index;

    rr_select #(
        .num_ports(num_ports)
    ) u_rr_select (
        .req        (cl_cmd_valid),
        .last_grant (last_grant_q),
        .found      (sel_found),
        .index      (sel_index)
    );

    // Next-state: grant latch, command capture and burst countdown.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        remaining_d  = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    grant_d = sel_index;
                    cmd_d   = mem_cmd_t'(cl_cmd_data[sel_index]);
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (mem_cmd_ready) begin
                    remaining_d = cmd_q.len;
                    if (cmd_q.len == 32'd0) begin
                        // Zero-length command still advances the rotation.
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                    end else if (cmd_q.read_not_write) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (cl_write_valid[grant_q] && mem_write_ready) begin
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                    end
                end
            end
            StRead: begin
                if (mem_read_valid && cl_read_ready[grant_q]) begin
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: only the granted client's handshakes are routed; everything else reads 0.
    always_comb begin
        cl_cmd_ready    = '0;
        cl_write_ready  = '0;
        cl_read_valid   = '0;
        cl_read_data    = '0;
        mem_cmd_valid   = 1'b0;
        mem_cmd_data    = cmd_q;
        mem_write_valid = 1'b0;
        mem_write_data  = '0;
        mem_read_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gate with reset so no client sees an accept while aresetn is low.
                if (sel_found && aresetn) begin
                    cl_cmd_ready[sel_index] = 1'b1;
                end
            end
            StCmd: begin
                mem_cmd_valid = 1'b1;
            end
            StWrite: begin
                mem_write_valid         = cl_write_valid[grant_q];
                mem_write_data          = cl_write_data[grant_q];
                cl_write_ready[grant_q] = mem_write_ready;
            end
            StRead: begin
                cl_read_valid[grant_q] = mem_read_valid;
                cl_read_data[grant_q]  = mem_read_data;
                mem_read_ready         = cl_read_ready[grant_q];
            end
            default: ;
        endcase
    end

    // State registers; last_grant resets to the top port so port 0 wins first.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IdxW'(num_ports - 1);
            cmd_q        <= '0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            remaining_q  <= remaining_d;
        end
    end

endmodule

// File: tb/tb_mem_client_arbiter.sv
// Directed bench for mem_client_arbiter: transaction table plus hand-written corner sequences.
module tb_mem_client_arbiter;

    localparam int NP = 4;
    localparam int MW = 32;

    logic                   clk;
    logic                   aresetn;
    logic [NP-1:0]          cl_cmd_valid;
    logic [NP-1:0]          cl_cmd_ready;
    logic [NP-1:0][64:0]    cl_cmd_data;
    logic [NP-1:0]          cl_write_valid;
    logic [NP-1:0]          cl_write_ready;
    logic [NP-1:0][MW-1:0]  cl_write_data;
    logic [NP-1:0]          cl_read_valid;
    logic [NP-1:0]          cl_read_ready;
    logic [NP-1:0][MW-1:0]  cl_read_data;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic [64:0]            mem_cmd_data;
    logic                   mem_write_valid;
    logic                   mem_write_ready;
    logic [MW-1:0]          mem_write_data;
    logic                   mem_read_valid;
    logic                   mem_read_ready;
    logic [MW-1:0]          mem_read_data;

    int checks = 0;
    int errors = 0;

    mem_client_arbiter #(
        .num_ports(NP),
        .mem_width(MW)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .cl_cmd_valid    (cl_cmd_valid),
        .cl_cmd_ready    (cl_cmd_ready),
        .cl_cmd_data     (cl_cmd_data),
        .cl_write_valid  (cl_write_valid),
        .cl_write_ready  (cl_write_ready),
        .cl_write_data   (cl_write_data),
        .cl_read_valid   (cl_read_valid),
        .cl_read_ready   (cl_read_ready),
        .cl_read_data    (cl_read_data),
        .mem_cmd_valid   (mem_cmd_valid),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_cmd_data    (mem_cmd_data),
        .mem_write_valid (mem_write_valid),
        .mem_write_ready (mem_write_ready),
        .mem_write_data  (mem_write_data),
        .mem_read_valid  (mem_read_valid),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          port;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] base;
        bit          bp;
        logic [3:0]  others;
        logic [64:0] exp_cmd;
    } txn_t;

    txn_t tbl[4];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one client transaction; starts and ends on a falling edge.
    task automatic run_txn(input txn_t t);
        int          k;
        int          cyc;
        int          beats;
        logic        rdy;
        logic [31:0] word;
        cl_cmd_valid = t.others | (4'b0001 << t.port);
        cl_cmd_data[t.port] = {t.rnw, t.addr, t.len};
        #1 check("cmd_ready_grant", cl_cmd_ready, 4'b0001 << t.port);
        @(negedge clk);
        cl_cmd_valid  = '0;
        mem_cmd_ready = 1'b1;
        #1 check("mem_cmd_valid", mem_cmd_valid, 1'b1);
        check("mem_cmd_data", mem_cmd_data, t.exp_cmd);
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        k = 0;
        cyc = 0;
        beats = 0;
        while (k < int'(t.len) && cyc < 64) begin
            rdy = t.bp ? (cyc % 2 == 0) : 1'b1;
            if (!t.rnw) begin
                word = t.base + 32'(k);
                cl_write_valid = 4'b0001 << t.port;
                cl_write_data[t.port] = word;
                mem_write_ready = rdy;
                #1 check("wr_valid", mem_write_valid, 1'b1);
                check("wr_data", mem_write_data, word);
                check("cl_wr_ready", cl_write_ready, rdy ? (4'b0001 << t.port) : 4'b0000);
                if (mem_write_valid && mem_write_ready) beats++;
            end else begin
                word = t.base * 32'(k + 1);
                mem_read_valid = 1'b1;
                mem_read_data  = word;
                cl_read_ready  = rdy ? (4'b0001 << t.port) : 4'b0000;
                #1 check("rd_valid", cl_read_valid, 4'b0001 << t.port);
                check("rd_data", cl_read_data[t.port], word);
                check("mem_rd_ready", mem_read_ready, rdy);
                if (mem_read_ready && mem_read_valid) beats++;
            end
            if (rdy) k++;
            @(negedge clk);
            cyc++;
        end
        check("burst_done", k, t.len);
        check("beat_count", beats, t.len);
        // Data phase must be closed: offered data is no longer passed through.
        cl_write_valid  = 4'b0001 << t.port;
        mem_write_ready = 1'b1;
        mem_read_valid  = 1'b1;
        cl_read_ready   = 4'b0001 << t.port;
        #1 check("idle_wr_valid", mem_write_valid, 1'b0);
        check("idle_rd_ready", mem_read_ready, 1'b0);
        check("idle_rd_valid", cl_read_valid, 4'b0000);
        cl_write_valid  = '0;
        mem_write_ready = 1'b0;
        mem_read_valid  = 1'b0;
        cl_read_ready   = '0;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{port: 2, rnw: 1'b0, addr: 32'h100, len: 32'd4, base: 32'hA0, bp: 1'b0,
                   others: 4'b0000, exp_cmd: 65'h0_00000100_00000004};
        tbl[1] = '{port: 1, rnw: 1'b1, addr: 32'h40, len: 32'd3, base: 32'h11, bp: 1'b0,
                   others: 4'b0000, exp_cmd: 65'h1_00000040_00000003};
        tbl[2] = '{port: 3, rnw: 1'b1, addr: 32'h0, len: 32'd0, base: 32'h0, bp: 1'b0,
                   others: 4'b0000, exp_cmd: 65'h1_00000000_00000000};
        // After the zero-length grant to port 3, port 0 must win over 1..3.
        tbl[3] = '{port: 0, rnw: 1'b0, addr: 32'h200, len: 32'd8, base: 32'hB0, bp: 1'b1,
                   others: 4'b1110, exp_cmd: 65'h0_00000200_00000008};

        aresetn         = 1'b0;
        cl_cmd_valid    = '0;
        cl_cmd_data     = '0;
        cl_write_valid  = '0;
        cl_write_data   = '0;
        cl_read_ready   = '0;
        mem_cmd_ready   = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_valid  = 1'b0;
        mem_read_data   = '0;

        repeat (2) @(negedge clk);
        #1 check("rst_mem_cmd_valid", mem_cmd_valid, 1'b0);
        check("rst_mem_cmd_data", mem_cmd_data, 65'h0);
        check("rst_cmd_ready", cl_cmd_ready, 4'b0000);
        check("rst_mem_rd_ready", mem_read_ready, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // Contention: all ports request single-word writes; grant order 0,1,2,3.
        begin
            logic [3:0] v;
            v = 4'hF;
            for (int p = 0; p < NP; p++) cl_cmd_data[p] = {1'b0, 32'h300 + 32'(p), 32'd1};
            for (int g = 0; g < NP; g++) begin
                cl_cmd_valid = v;
                #1 check("cont_grant", cl_cmd_ready, 4'b0001 << g);
                @(negedge clk);
                v[g] = 1'b0;
                cl_cmd_valid  = v;
                mem_cmd_ready = 1'b1;
                #1 check("cont_cmd_data", mem_cmd_data, {1'b0, 32'h300 + 32'(g), 32'd1});
                check("cont_no_ready_in_cmd", cl_cmd_ready, 4'b0000);
                @(negedge clk);
                mem_cmd_ready   = 1'b0;
                cl_write_valid  = 4'b0001 << g;
                cl_write_data[g] = 32'hC0 + 32'(g);
                mem_write_ready = 1'b1;
                #1 check("cont_wr_data", mem_write_data, 32'hC0 + 32'(g));
                @(negedge clk);
                cl_write_valid  = '0;
                mem_write_ready = 1'b0;
            end
            // Re-request from ports 0 and 1 after port 3: rotation wraps to 0.
            cl_cmd_valid = 4'b0011;
            #1 check("cont_wrap", cl_cmd_ready, 4'b0001);
            @(negedge clk);
            cl_cmd_valid  = '0;
            mem_cmd_ready = 1'b1;
            @(negedge clk);
            mem_cmd_ready   = 1'b0;
            cl_write_valid  = 4'b0001;
            mem_write_ready = 1'b1;
            @(negedge clk);
            cl_write_valid  = '0;
            mem_write_ready = 1'b0;
        end

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // Reset in the middle of a 5-word read on port 2.
        cl_cmd_valid   = 4'b0100;
        cl_cmd_data[2] = {1'b1, 32'h80, 32'd5};
        #1 check("mr_grant", cl_cmd_ready, 4'b0100);
        @(negedge clk);
        cl_cmd_valid  = '0;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = 32'h51 + 32'(k);
            cl_read_ready  = 4'b0100;
            #1 check("mr_rd_data", cl_read_data[2], 32'h51 + 32'(k));
            @(negedge clk);
        end
        mem_read_data   = 32'h53;
        cl_cmd_valid    = 4'b0110;
        cl_write_valid  = 4'b0100;
        mem_write_ready = 1'b1;
        aresetn         = 1'b0;
        #1 check("mr_rst_rd_valid", cl_read_valid, 4'b0000);
        check("mr_rst_mem_rd_ready", mem_read_ready, 1'b0);
        check("mr_rst_cmd_ready", cl_cmd_ready, 4'b0000);
        check("mr_rst_cmd_valid", mem_cmd_valid, 1'b0);
        check("mr_rst_cmd_data", mem_cmd_data, 65'h0);
        check("mr_rst_wr_valid", mem_write_valid, 1'b0);
        check("mr_rst_wr_ready", cl_write_ready, 4'b0000);
        check("mr_rst_wr_data", mem_write_data, 32'h0);
        for (int p = 0; p < NP; p++) check("mr_rst_rd_data", cl_read_data[p], 32'h0);
        @(negedge clk);
        aresetn         = 1'b1;
        cl_write_valid  = '0;
        mem_write_ready = 1'b0;
        mem_read_valid  = 1'b0;
        cl_read_ready   = '0;
        cl_cmd_valid    = 4'b1111;
        #1 check("mr_first_grant", cl_cmd_ready, 4'b0001);
        @(negedge clk);
        cl_cmd_valid = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
